ext_int_ctrl: RTL and testbench
===============================

Name: ext_int_ctrl

Overview:
- Parametrised external-interrupt controller; successor of the single-line INTE latch.
- Accepts N_SRC hardware lines with per-source edge/level mode and a per-source enable mask; gates with MSR[EE]; selects the highest-priority pending source; drives intReq to the interrupt encoder.
- Holds the request until the core acknowledges (SRR0/SRR1 written), then tracks the in-service source until software issues end-of-interrupt.

Parameters:
- N_SRC, 8, number of external interrupt lines (1..32).
- IDX_W, 3, width of source index; must satisfy 2**IDX_W >= N_SRC.
- EDGE_MODE, 8'h00, N_SRC-bit map; bit i=1 means source i is rising-edge sensitive, 0 means level (active-high).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- hw_int  in  N_SRC  raw interrupt lines, already synchronous to clk
- int_en  in  N_SRC  per-source enable mask (from SPR)
- EE  in  1  MSR[EE]
- int_ack  in  1  one-cycle pulse: core has taken the external interrupt
- int_eoi  in  1  one-cycle pulse: software end-of-interrupt
- intReq  out  1  external interrupt request to the encoder
- src_id  out  IDX_W  index of the requested/in-service source
- in_service  out  1  an acknowledged interrupt is being serviced
- pend  out  N_SRC  raw pending register, for mfspr readback

Behaviour:
- Reset: rst_n sampled low at a clk edge clears pend, the previous-input register, src_id and in_service; intReq=0; state=IDLE. Reset has priority over every other input, including mid-REQ and mid-SERVICE.
- Pending, level source i: pend[i] <= hw_int[i] on every edge. int_ack does not clear it; the device must drop the line.
- Pending, edge source i: pend[i] is set on a sampled 0->1 transition of hw_int[i]. It is cleared on int_ack when i == src_id.
  - If a set and a clear for the same bit coincide, set wins.
  - The previous-input register resets to 0, so a line already high at reset release counts as an edge.
- Eligible vector: elig = pend & int_en. Priority is fixed: lowest index wins.
- FSM states:
  - IDLE: intReq=0, in_service=0. If EE=1 and elig != 0, go to REQ and latch src_id = highest-priority index.
  - REQ: intReq=1. src_id is re-evaluated every cycle, so a higher-priority arrival preempts before ack.
    - If EE=0 or elig == 0, return to IDLE with intReq=0 next cycle (withdrawn request).
    - On int_ack: go to SERVICE, freeze src_id, clear the edge pend bit as above.
  - SERVICE: intReq=0, in_service=1, src_id frozen. New pends still accumulate. On int_eoi, go to IDLE.
- No nesting: a second request is never raised while in SERVICE.
- Ignored inputs: int_ack outside REQ, and int_eoi outside SERVICE.
- Simultaneous int_ack and int_eoi in REQ: int_ack is taken and int_eoi is ignored.
- Latency (edge source): hw_int rises, sampled at edge k -> pend set after k -> state=REQ after k+1 -> intReq high in the cycle following edge k+1.
- Latency (level source): identical.
- Latency (eoi): int_eoi sampled at edge m -> IDLE after m -> next REQ no earlier than after m+1.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to intReq.
- int_en changes take effect on elig in the same cycle they are applied.

Decomposition:
- Shared package (extend ctrl_encode_def):
  - FSM state encoding `EIC_IDLE/`EIC_REQ/`EIC_SVC, 2 bits.
  - The external-interrupt IVOR index constant (4) used with INTOp_EXT.
  - Default values for N_SRC and IDX_W.
- Sub-module int_prio_enc: parametrised N_SRC-to-IDX_W lowest-index-first priority encoder with a valid flag. It is purely combinational and reusable for a future critical-interrupt controller.

Test Plan:
- Reset mid-operation: drive to SERVICE, then rst_n=0 for 1 cycle -> pend=0, src_id=0, intReq=0, in_service=0 on the next cycle.
- Edge source 3 pulses one cycle with EE=1 and int_en=8'hFF:
  - intReq=1 two cycles after the pulse, src_id=3.
  - After int_ack: in_service=1, pend[3]=0, intReq=0.
  - After int_eoi: IDLE.
- Priority preempt: level src 5 asserted -> REQ with src_id=5; raise src 1 before ack -> src_id=1 next cycle; int_ack freezes 1.
- EE gating and withdrawal:
  - src 2 level high with EE=0 -> intReq stays 0.
  - Set EE=1 -> intReq=1.
  - Drop EE before ack -> intReq=0 the next cycle; state IDLE.
- Mask and set-wins collision:
  - int_en[4]=0 with src 4 pending -> no request; pend[4] readable as 1.
  - Edge on src 0 coincident with int_ack of src 0 -> pend[0] remains 1, and REQ src_id=0 re-raises after eoi.
- Level hold and spurious handshakes:
  - Level src 7 held through SERVICE -> after int_eoi, intReq=1 again, src_id=7.
  - int_ack pulsed in IDLE -> no state change.

Source files
------------

// File: rtl/ext_int_ctrl_pkg.sv
// rtl/ext_int_ctrl_pkg.sv - shared constants and FSM encoding for the external-interrupt controller
//
// Purpose : common definitions imported by ext_int_ctrl and its priority encoder.
//   - EIC_N_SRC_DEF / EIC_IDX_W_DEF : default line count and index width
//   - IVOR_EXT_IDX                  : IVOR slot used with INTOp_EXT
//   - eic_state_e                   : controller FSM state encoding (2 bits)

package ext_int_ctrl_pkg;

   localparam int EIC_N_SRC_DEF = 8;
   localparam int EIC_IDX_W_DEF = 3;

   // External interrupts vector through IVOR4.
   localparam logic [4:0] IVOR_EXT_IDX = 5'd4;

   typedef enum logic [1:0] {
      EIC_IDLE = 2'd0,
      EIC_REQ  = 2'd1,
      EIC_SVC  = 2'd2
   } eic_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder with valid flag
//
// Purpose : purely combinational; reports the index of the lowest set bit of req.
// Ports   :
//   req   in  N_SRC  request vector
//   idx   out IDX_W  index of the lowest set bit (0 when nothing is set)
//   valid out 1      at least one bit of req is set

module int_prio_enc #(
   parameter int N_SRC = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_SRC-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ext_int_ctrl.sv
// rtl/ext_int_ctrl.sv - parametrised external-interrupt controller
//
// Purpose : collects N_SRC interrupt lines (per-source edge/level), masks them with
//           int_en, gates with MSR[EE], requests the highest-priority source and
//           tracks it in service until end-of-interrupt.
// Ports   :
//   clk        in  1      core clock
//   rst_n      in  1      synchronous reset, active-low
//   hw_int     in  N_SRC  raw interrupt lines, synchronous to clk
//   int_en     in  N_SRC  per-source enable mask
//   EE         in  1      MSR[EE]
//   int_ack    in  1      pulse: core has taken the external interrupt
//   int_eoi    in  1      pulse: software end-of-interrupt
//   intReq     out 1      request to the interrupt encoder
//   src_id     out IDX_W  requested / in-service source index
//   in_service out 1      an acknowledged interrupt is being serviced
//   pend       out N_SRC  raw pending register

module ext_int_ctrl
   import ext_int_ctrl_pkg::*;
#(
   parameter int               N_SRC     = EIC_N_SRC_DEF,
   parameter int               IDX_W     = EIC_IDX_W_DEF,
   parameter logic [N_SRC-1:0] EDGE_MODE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] hw_int,
   input  logic [N_SRC-1:0] int_en,
   input  logic             EE,
   input  logic             int_ack,
   input  logic             int_eoi,
   output logic             intReq,
   output logic [IDX_W-1:0] src_id,
   output logic             in_service,
   output logic [N_SRC-1:0] pend
);

   eic_state_e       state_q, state_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] prev_q;
   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] ack_clr;
   logic [IDX_W-1:0] src_q, src_d;
   logic [IDX_W-1:0] best_idx;
   logic             best_vld;
   logic             ack_take;

   // Mask is applied combinationally so int_en changes act in the same cycle.
   assign elig = pend_q & int_en;

   int_prio_enc #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_prio (
      .req   (elig),
      .idx   (best_idx),
      .valid (best_vld)
   );

   assign ack_take = (state_q == EIC_REQ) && int_ack;
   assign rise     = hw_int & ~prev_q;

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = ack_take && (int'(src_q) == i);
      end
   end

   // Edge sources: a new rise wins over a coincident ack clear.
   // Level sources: simply follow the line; the device must drop it.
   assign pend_d = (EDGE_MODE & (rise | (pend_q & ~ack_clr)))
                 | (~EDGE_MODE & hw_int);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      case (state_q)
         EIC_IDLE: begin
            if (EE && best_vld) begin
               state_d = EIC_REQ;
               src_d   = best_idx;
            end
         end
         EIC_REQ: begin
            // An ack means the core has already taken this source, so it
            // outranks a withdrawal seen on the same edge.
            if (int_ack) begin
               state_d = EIC_SVC;
            end else if (!EE || !best_vld) begin
               state_d = EIC_IDLE;
            end else begin
               src_d = best_idx;
            end
         end
         EIC_SVC: begin
            if (int_eoi) begin
               state_d = EIC_IDLE;
            end
         end
         default: state_d = EIC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EIC_IDLE;
         pend_q  <= '0;
         prev_q  <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         prev_q  <= hw_int;
         src_q   <= src_d;
      end
   end

   assign intReq     = (state_q == EIC_REQ);
   assign in_service = (state_q == EIC_SVC);
   assign src_id     = src_q;
   assign pend       = pend_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb/tb_ext_int_ctrl.sv - self-checking bench for ext_int_ctrl

module tb_ext_int_ctrl;

   localparam int           N    = 8;
   localparam int           W    = 3;
   localparam logic [N-1:0] EDGE = 8'h09;  // sources 0 and 3 edge, others level

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] hw_int;
   logic [N-1:0] int_en;
   logic         EE;
   logic         int_ack;
   logic         int_eoi;
   logic         intReq;
   logic [W-1:0] src_id;
   logic         in_service;
   logic [N-1:0] pend;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: mode 0 = idle, 1 = requesting, 2 = in service.
   logic [N-1:0] m_pend;
   logic [N-1:0] m_prev;
   int           m_src;
   int           m_mode;

   always #5 clk = ~clk;

   ext_int_ctrl #(
      .N_SRC     (N),
      .IDX_W     (W),
      .EDGE_MODE (EDGE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hw_int     (hw_int),
      .int_en     (int_en),
      .EE         (EE),
      .int_ack    (int_ack),
      .int_eoi    (int_eoi),
      .intReq     (intReq),
      .src_id     (src_id),
      .in_service (in_service),
      .pend       (pend)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_clock();
      logic [N-1:0] np;
      int           best;
      if (!rst_n) begin
         m_pend = '0;
         m_prev = '0;
         m_src  = 0;
         m_mode = 0;
         return;
      end
      best = lowest(m_pend & int_en);
      for (int i = 0; i < N; i++) begin
         if (EDGE[i]) begin
            if (hw_int[i] && !m_prev[i])                      np[i] = 1'b1;
            else if (m_mode == 1 && int_ack && m_src == i)    np[i] = 1'b0;
            else                                              np[i] = m_pend[i];
         end else begin
            np[i] = hw_int[i];
         end
      end
      if (m_mode == 0) begin
         if (EE && best >= 0) begin
            m_mode = 1;
            m_src  = best;
         end
      end else if (m_mode == 1) begin
         if (int_ack)                 m_mode = 2;
         else if (!EE || best < 0)    m_mode = 0;
         else                         m_src  = best;
      end else begin
         if (int_eoi) m_mode = 0;
      end
      m_prev = hw_int;
      m_pend = np;
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      chk("intReq", {31'd0, intReq}, {31'd0, m_mode == 1});
      chk("in_service", {31'd0, in_service}, {31'd0, m_mode == 2});
      chk("src_id", {29'd0, src_id}, m_src);
      chk("pend", {24'd0, pend}, {24'd0, m_pend});
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      int_eoi = 1'b1;
      step();
      int_eoi = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      hw_int  = '0;
      int_en  = '1;
      EE      = 1'b1;
      int_ack = 1'b0;
      int_eoi = 1'b0;
      m_pend  = '0;
      m_prev  = '0;
      m_src   = 0;
      m_mode  = 0;
      step();
      step();
      chk("rst_req", {31'd0, intReq}, 32'd0);
      chk("rst_pend", {24'd0, pend}, 32'd0);
      rst_n = 1'b1;
      step();

      // Edge source 3 one-cycle pulse
      hw_int[3] = 1'b1;
      step();
      hw_int[3] = 1'b0;
      step();
      chk("e3_req", {31'd0, intReq}, 32'd1);
      chk("e3_id", {29'd0, src_id}, 32'd3);
      pulse_ack();
      chk("e3_svc", {31'd0, in_service}, 32'd1);
      chk("e3_pend", {31'd0, pend[3]}, 32'd0);
      chk("e3_noreq", {31'd0, intReq}, 32'd0);
      pulse_eoi();
      chk("e3_idle", {30'd0, intReq, in_service}, 32'd0);
      step();

      // Priority preempt
      hw_int[5] = 1'b1;
      step();
      step();
      chk("pr_id5", {29'd0, src_id}, 32'd5);
      hw_int[1] = 1'b1;
      step();
      step();
      chk("pr_id1", {29'd0, src_id}, 32'd1);
      pulse_ack();
      hw_int[5] = 1'b0;
      step();
      chk("pr_frz", {29'd0, src_id}, 32'd1);
      chk("pr_svc", {31'd0, in_service}, 32'd1);
      hw_int[1] = 1'b0;
      pulse_eoi();
      step();

      // EE gating and withdrawal
      EE = 1'b0;
      hw_int[2] = 1'b1;
      step();
      step();
      step();
      chk("ee_off", {31'd0, intReq}, 32'd0);
      EE = 1'b1;
      step();
      chk("ee_on", {31'd0, intReq}, 32'd1);
      chk("ee_id", {29'd0, src_id}, 32'd2);
      EE = 1'b0;
      step();
      chk("ee_wdr", {31'd0, intReq}, 32'd0);
      hw_int[2] = 1'b0;
      step();
      EE = 1'b1;
      step();

      // Mask
      int_en = 8'hEF;
      hw_int[4] = 1'b1;
      step();
      step();
      step();
      chk("msk_req", {31'd0, intReq}, 32'd0);
      chk("msk_pend", {31'd0, pend[4]}, 32'd1);
      hw_int[4] = 1'b0;
      step();
      int_en = '1;
      step();

      // Set-wins collision on edge source 0
      hw_int[0] = 1'b1;
      step();
      hw_int[0] = 1'b0;
      step();
      chk("sw_id", {29'd0, src_id}, 32'd0);
      hw_int[0] = 1'b1;
      pulse_ack();
      hw_int[0] = 1'b0;
      chk("sw_pend", {31'd0, pend[0]}, 32'd1);
      chk("sw_svc", {31'd0, in_service}, 32'd1);
      pulse_eoi();
      step();
      chk("sw_rereq", {31'd0, intReq}, 32'd1);
      chk("sw_reid", {29'd0, src_id}, 32'd0);
      pulse_ack();
      pulse_eoi();
      step();

      // Level source 7 held through service
      hw_int[7] = 1'b1;
      step();
      step();
      pulse_ack();
      step();
      pulse_eoi();
      step();
      chk("lv_rereq", {31'd0, intReq}, 32'd1);
      chk("lv_id", {29'd0, src_id}, 32'd7);
      hw_int[7] = 1'b0;
      pulse_ack();
      pulse_eoi();
      step();

      // Spurious handshakes in IDLE
      pulse_ack();
      chk("sp_ack", {30'd0, intReq, in_service}, 32'd0);
      pulse_eoi();
      chk("sp_eoi", {30'd0, intReq, in_service}, 32'd0);

      // Reset mid-service
      hw_int[3] = 1'b1;
      step();
      hw_int[3] = 1'b0;
      step();
      hw_int[6] = 1'b1;
      pulse_ack();
      chk("rs_svc", {31'd0, in_service}, 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rs_pend", {24'd0, pend}, 32'd0);
      chk("rs_id", {29'd0, src_id}, 32'd0);
      chk("rs_out", {30'd0, intReq, in_service}, 32'd0);
      hw_int = '0;
      step();

      // Randomised traffic against the model
      for (int c = 0; c < 800; c++) begin
         rst_n   = ($urandom_range(0, 99) != 0);
         EE      = ($urandom_range(0, 7) != 0);
         int_en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         hw_int  = hw_int ^ (N'($urandom) & N'($urandom) & N'($urandom));
         int_ack = ($urandom_range(0, 3) == 0);
         int_eoi = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
